// File: rtl/alink_txc.sv
// alink_txc -- alink serial task transmit controller.
//
// Pops one TASK_LEN-word task from the show-ahead TX FIFO. Each word is sent
// MSB first as P/N pulses on one lane. A P=N=1 marker closes the frame.
// The lane is the lowest enabled bit of (tx_phy_sel & ~reg_mask), latched at
// frame start. If no lane is enabled, the task is popped and discarded.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   reg_flush       synchronous abort back to idle
//   reg_mask        per-lane disable (1 = disabled)
//   tx_phy_sel      target lane select, sampled at frame start
//   tx_req / tx_dat FIFO holds a full task / FIFO head word (show-ahead)
//   tx_rd           FIFO pop strobe
//   tx_busy         frame in progress
//   tx_phy_start    pulse at the first word load of a frame
//   tx_phy_done     pulse at frame end or drop end
//   tx_drop         pulse with tx_phy_done when the task was discarded
//   TX_P / TX_N     registered per-lane pulse lines
module alink_txc #(
  parameter int unsigned PHY_NUM  = 16,
  parameter int unsigned TASK_LEN = 23,
  parameter int unsigned BIT_CYC  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reg_flush,
  input  logic [31:0]        reg_mask,
  input  logic [31:0]        tx_phy_sel,
  input  logic               tx_req,
  input  logic [31:0]        tx_dat,
  output logic               tx_rd,
  output logic               tx_busy,
  output logic               tx_phy_start,
  output logic               tx_phy_done,
  output logic               tx_drop,
  output logic [PHY_NUM-1:0] TX_P,
  output logic [PHY_NUM-1:0] TX_N
);

  localparam int unsigned PW = (BIT_CYC  > 1) ? $clog2(BIT_CYC)  : 1;
  localparam int unsigned WW = (TASK_LEN > 1) ? $clog2(TASK_LEN) : 1;
  localparam int unsigned LW = (PHY_NUM  > 1) ? $clog2(PHY_NUM)  : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(BIT_CYC - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(TASK_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, BIT_ON, BIT_OFF, EOF, DROP, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]       word_q, word_d;
  logic [31:0]         shift_q, shift_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic                tx_rd_q, tx_rd_d;
  logic                tx_busy_q, tx_busy_d;
  logic                tx_start_q, tx_start_d;
  logic                tx_done_q, tx_done_d;
  logic                tx_drop_q, tx_drop_d;
  logic [PHY_NUM-1:0]  tx_p_q, tx_p_d;
  logic [PHY_NUM-1:0]  tx_n_q, tx_n_d;

  logic [31:0]         eff;
  logic                eff_any;
  logic [LW-1:0]       lane_sel;
  logic                phase_done;
  logic [PHY_NUM-1:0]  lane_hot;

  // Lowest enabled lane; bits at or above PHY_NUM never qualify.
  always_comb begin
    eff      = tx_phy_sel & ~reg_mask;
    eff_any  = 1'b0;
    lane_sel = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (eff[i] && (i < PHY_NUM) && !eff_any) begin
        eff_any  = 1'b1;
        lane_sel = LW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q + PW'(1);
    bit_cnt_d  = bit_cnt_q;
    word_d     = word_q;
    shift_d    = shift_q;
    lane_d     = lane_q;
    phase_done = (phase_q == PH_LAST);

    case (state_q)
      IDLE: begin
        if (tx_req && !reg_flush) begin
          word_d = '0;
          if (eff_any) begin
            state_d = LOAD;
            lane_d  = lane_sel;
          end else begin
            state_d = DROP;
          end
        end
      end
      LOAD: begin
        shift_d   = tx_dat;
        bit_cnt_d = 5'd31;
        state_d   = BIT_ON;
      end
      BIT_ON: begin
        if (phase_done) state_d = BIT_OFF;
      end
      BIT_OFF: begin
        if (phase_done) begin
          if (bit_cnt_q != 5'd0) begin
            shift_d   = {shift_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 5'd1;
            state_d   = BIT_ON;
          end else if (word_q != WORD_LAST) begin
            word_d  = word_q + WW'(1);
            state_d = LOAD;
          end else begin
            state_d = EOF;
          end
        end
      end
      EOF: begin
        if (phase_done) state_d = DONE;
      end
      // word_q doubles as the drop-length counter.
      DROP: begin
        if (word_q == WORD_LAST) state_d = DONE;
        else                     word_d  = word_q + WW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (reg_flush) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      word_d    = '0;
      shift_d   = '0;
      lane_d    = '0;
    end

    if ((state_d != state_q) || (state_d == IDLE)) phase_d = '0;

    // Outputs are computed from the next state so they register in step with it.
    for (int unsigned i = 0; i < PHY_NUM; i++) begin
      lane_hot[i] = (lane_d == LW'(i));
    end
    tx_rd_d    = (state_d == LOAD) || (state_d == DROP);
    tx_busy_d  = (state_d != IDLE);
    tx_start_d = (state_d == LOAD) && (word_d == '0);
    tx_done_d  = (state_d == DONE);
    tx_drop_d  = (state_d == DONE) && (state_q == DROP);
    tx_p_d     = '0;
    tx_n_d     = '0;
    if (state_d == BIT_ON) begin
      if (shift_d[31]) tx_p_d = lane_hot;
      else             tx_n_d = lane_hot;
    end
    if (state_d == EOF) begin
      tx_p_d = lane_hot;
      tx_n_d = lane_hot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      lane_q     <= '0;
      tx_rd_q    <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
      tx_p_q     <= '0;
      tx_n_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      lane_q     <= lane_d;
      tx_rd_q    <= tx_rd_d;
      tx_busy_q  <= tx_busy_d;
      tx_start_q <= tx_start_d;
      tx_done_q  <= tx_done_d;
      tx_drop_q  <= tx_drop_d;
      tx_p_q     <= tx_p_d;
      tx_n_q     <= tx_n_d;
    end
  end

  assign tx_rd        = tx_rd_q;
  assign tx_busy      = tx_busy_q;
  assign tx_phy_start = tx_start_q;
  assign tx_phy_done  = tx_done_q;
  assign tx_drop      = tx_drop_q;
  assign TX_P         = tx_p_q;
  assign TX_N         = tx_n_q;

endmodule
